// File: rtl/execute_sequencer_if.sv
// X-stage instruction/handshake bundle between the pipeline and the execute sequencer.
// The master side drives the instruction and multdiv status; the slave is the sequencer.
interface execute_sequencer_if #(
    parameter int CNT_W = 7
);
    logic [31:0]      ins;
    logic             insValid;
    logic             flush;
    logic             multDivDone;
    logic             multDivException;
    logic [1:0]       insType;
    logic [4:0]       aluOpCode;
    logic [4:0]       shiftAmt;
    logic             aluBSelector;
    logic             startMult;
    logic             startDiv;
    logic             stall;
    logic             resultValid;
    logic             mdException;
    logic             timeout;
    logic [CNT_W-1:0] busyCount;

    modport master (
        output ins, insValid, flush, multDivDone, multDivException,
        input  insType, aluOpCode, shiftAmt, aluBSelector, startMult, startDiv,
               stall, resultValid, mdException, timeout, busyCount
    );

    modport slave (
        input  ins, insValid, flush, multDivDone, multDivException,
        output insType, aluOpCode, shiftAmt, aluBSelector, startMult, startDiv,
               stall, resultValid, mdException, timeout, busyCount
    );
endinterface

// File: rtl/execute_sequencer.sv
// Execute-stage decode plus IDLE/BUSY/DONE sequencing of multi-cycle mul/div,
// with stall generation and an optional timeout that forces completion.
module execute_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit DIV_ENABLE     = 1'b1,
    parameter int CNT_W          = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic                 clock,
    input logic                 reset,
    execute_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [1:0] TYPE_R   = 2'b00;
    localparam logic [1:0] TYPE_I   = 2'b01;
    localparam logic [1:0] TYPE_JI  = 2'b10;
    localparam logic [1:0] TYPE_JII = 2'b11;
    localparam logic [4:0] FN_MUL   = 5'b00110;
    localparam logic [4:0] FN_DIV   = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] busy_count_q, busy_count_d;
    logic             md_exc_q, md_exc_d;
    logic             timeout_q, timeout_d;

    logic [4:0] opcode, func;
    logic [1:0] ins_type;
    logic [4:0] alu_op;
    logic       b_sel;
    logic       is_md;
    logic       start_mult, start_div, stall, result_valid;

    logic unused_ins;
    assign unused_ins = ^{bus.ins[26:12], bus.ins[1:0]};

    assign opcode = bus.ins[31:27];
    assign func   = bus.ins[6:2];

    always_comb begin
        ins_type = TYPE_I;
        alu_op   = 5'b00000;
        b_sel    = 1'b0;
        case (opcode)
            5'b00000:                               begin ins_type = TYPE_R; alu_op = func; end
            5'b00101, 5'b00111, 5'b01000:           b_sel    = 1'b1;
            5'b00010, 5'b00110:                     alu_op   = 5'b00001;
            5'b00001, 5'b00011, 5'b10101, 5'b10110: ins_type = TYPE_JI;
            5'b00100:                               ins_type = TYPE_JII;
            default: ;
        endcase
    end

    assign is_md = bus.insValid && (opcode == 5'b00000) &&
                   ((func == FN_MUL) || (DIV_ENABLE && (func == FN_DIV)));

    always_comb begin
        state_d      = state_q;
        busy_count_d = busy_count_q;
        md_exc_d     = md_exc_q;
        timeout_d    = timeout_q;
        start_mult   = 1'b0;
        start_div    = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_md && !bus.flush) begin
                    start_mult   = (func == FN_MUL);
                    start_div    = (func == FN_DIV);
                    stall        = 1'b1;
                    state_d      = BUSY;
                    busy_count_d = '0;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // Priority: flush aborts, then a real result beats the timeout.
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.multDivDone) begin
                    state_d   = DONE;
                    md_exc_d  = bus.multDivException;
                    timeout_d = 1'b0;
                end else if ((TIMEOUT_CYCLES != 0) && (busy_count_q == TO_LAST)) begin
                    state_d   = DONE;
                    md_exc_d  = 1'b1;
                    timeout_d = 1'b1;
                end else if (busy_count_q != CNT_MAX) begin
                    busy_count_d = busy_count_q + 1'b1;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_count_q <= '0;
            md_exc_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_count_q <= busy_count_d;
            md_exc_q     <= md_exc_d;
            timeout_q    <= timeout_d;
        end
    end

    // Handshake outputs are killed combinationally so reset takes effect mid-cycle.
    assign bus.insType      = ins_type;
    assign bus.aluOpCode    = alu_op;
    assign bus.shiftAmt     = bus.ins[11:7];
    assign bus.aluBSelector = b_sel;
    assign bus.startMult    = start_mult & ~reset;
    assign bus.startDiv     = start_div & ~reset;
    assign bus.stall        = stall & ~reset;
    assign bus.resultValid  = result_valid & ~reset;
    assign bus.mdException  = (state_q == DONE) & md_exc_q & ~reset;
    assign bus.timeout      = (state_q == DONE) & timeout_q & ~reset;
    assign bus.busyCount    = busy_count_q;

endmodule

// File: doc/execute_sequencer.md
# execute_sequencer

Execute-stage control for the 32-bit pipeline: decodes the instruction in X into ALU controls and sequences multi-cycle multiply/divide operations. It issues start pulses to the multdiv unit, stalls the pipeline until the unit finishes or a programmable timeout expires, and reports result-valid, exception and flush status to the X/M latch and the exception logic.

## Interface
- TIMEOUT_CYCLES, 64: maximum BUSY cycles before forced completion; 0 disables the timeout.
- DIV_ENABLE, 1: 1 = div (ALU op 00111) is sequenced; 0 = div is decoded as a plain single-cycle ALU op and never stalls.
- CNT_W, $clog2(TIMEOUT_CYCLES+1) (minimum 1): width of busyCount.
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ins  in  32  instruction in X stage.
- insValid  in  1  ins is a real instruction, not a bubble.
- flush  in  1  squash X (branch/exception); aborts any sequence in progress.
- multDivDone  in  1  multdiv unit result ready.
- multDivException  in  1  multdiv error; sampled only together with multDivDone.
- insType  out  2  00 R, 01 I, 10 JI, 11 JII.
- aluOpCode  out  5  ALU operation.
- shiftAmt  out  5  ins[11:7].
- aluBSelector  out  1  1 = immediate operand.
- startMult, startDiv  out  1  one-cycle start pulses.
- stall  out  1  hold F/D/X.
- resultValid  out  1  multdiv result ready for X/M this cycle.
- mdException  out  1  multdiv error or timeout, valid with resultValid.
- timeout  out  1  completion was forced by the timeout.
- busyCount  out  CNT_W  BUSY cycles elapsed.

## Operation
- Type decode on ins[31:27]:
  - 00000 → R.
  - addi 00101, sw 00111, lw 01000, bne 00010, blt 00110 → I.
  - j 00001, jal 00011, setx 10101, bex 10110 → JI.
  - jr 00100 → JII.
  - Any other opcode → I.
- aluOpCode:
  - R: ins[6:2].
  - bne/blt: 00001 (subtract).
  - All other types: 00000.
- aluBSelector: 1 for addi/sw/lw only.
- Decode outputs are combinational and are valid regardless of insValid or FSM state.
- MD op: insValid & R & (aluOp 00110, or aluOp 00111 with DIV_ENABLE=1).
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - If MD op and !flush: assert startMult or startDiv combinationally, assert stall, go to BUSY, clear busyCount.
  - Otherwise stay in IDLE with stall=0.
- BUSY:
  - stall=1.
  - If flush: go to IDLE; no resultValid.
  - Else if multDivDone: go to DONE; latch mdException=multDivException, timeout=0.
  - Else if TIMEOUT_CYCLES≠0 and busyCount==TIMEOUT_CYCLES-1: go to DONE; latch mdException=1, timeout=1.
  - Else busyCount+1.
- DONE:
  - stall=0, resultValid=1; mdException and timeout driven from their latches.
  - Go to IDLE unconditionally. The mul/div still present on ins this cycle never restarts.
- Simultaneous events:
  - multDivDone and timeout in the same cycle: done wins.
  - flush and multDivDone in the same cycle: flush wins.
  - multDivDone or multDivException while in IDLE or DONE: ignored.
- busyCount saturates at 2^CNT_W-1 when the timeout is disabled.
- Reset, asserted at any time including mid-sequence:
  - FSM goes to IDLE; busyCount, the latches, stall, resultValid, start pulses, mdException and timeout all go to 0.
  - The decode outputs still follow ins.

## Timing
- Cycle 0: MD op seen in IDLE → start pulse and stall in that same cycle.
- Cycles 1..n: BUSY; busyCount equals the BUSY cycle index (0 in cycle 1).
- multDivDone in cycle k → DONE and resultValid in cycle k+1, stall=0 in k+1.
- Minimum stall is 2 cycles (done arrives in cycle 1).
- Timeout forces DONE in cycle TIMEOUT_CYCLES+1.
- Start pulses are exactly one cycle wide and occur only in IDLE.

## Test plan
- Decode: ins=0x28440005 (addi) → insType 01, aluOp 00000, aluBSelector 1. ins=0x00443210 (sll) → insType 00, aluOp 00100, shiftAmt 4. No stall on either.
- mul: ins=0x00443018, insValid=1, done at cycle 3 → startMult high only in cycle 0; stall in cycles 0–3; resultValid in cycle 4; busyCount 2 in cycle 3.
- div with exception: ins=0x0044301C, done=1 and exception=1 in cycle 1 → startDiv in cycle 0, DONE in cycle 2 with mdException=1, timeout=0. Repeat with DIV_ENABLE=0 → no startDiv, no stall.
- Timeout: TIMEOUT_CYCLES=4, mul, no done → DONE in cycle 5 with timeout=1 and mdException=1. Done arriving on the timeout cycle → timeout=0.
- Flush: mul, flush in cycle 2 → IDLE in cycle 3, resultValid never asserted, stall=0 in cycle 3. A new mul in cycle 3 restarts with busyCount=0.
- Reset mid-BUSY: assert reset in cycle 2 between clock edges → stall, startMult and resultValid go to 0 immediately; after release the FSM is in IDLE.
